// File: rtl/me_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : me_result_fifo
// Purpose  : Captures MotionEstimator results (BestDist, motionX, motionY) on
//            me_done, tags each one with its raster block position, buffers it
//            in a show-ahead FIFO and hands it to the packer over valid/ready.
//            Also keeps per-frame bookkeeping: SAD sum, frame-done pulse and a
//            sticky overflow flag.
// Ports    : clock, reset (async, active-high)
//            frame_start            - clears frame bookkeeping / block position
//            me_done, BestDist,
//            motionX, motionY       - result strobe and payload
//            out_valid/out_ready    - output handshake, out_data = FIFO head
//            count                  - FIFO occupancy
//            frame_sad_sum          - saturating BestDist sum of accepted pushes
//            frame_done             - pulse after the frame's last block pops
//            overflow               - sticky, set when a push is dropped
//            skip_count             - (MV_SKIP_EN only) accepted skip blocks
// Options  : MV_SKIP_EN - adds skip flag as out_data[24] and skip_count port.
// Revision : 1.0 - initial release
// ============================================================================
module me_result_fifo #(
  parameter int DEPTH       = 8,
  parameter int BLOCKS_X    = 4,
  parameter int BLOCKS_Y    = 4,
  parameter int SKIP_THRESH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     me_done,
  input  logic [7:0]               BestDist,
  input  logic [3:0]               motionX,
  input  logic [3:0]               motionY,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef MV_SKIP_EN
  output logic [24:0]              out_data,
  output logic [7:0]               skip_count,
`else
  output logic [23:0]              out_data,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              frame_sad_sum,
  output logic                     frame_done,
  output logic                     overflow
);

`ifdef MV_SKIP_EN
  localparam int DW = 25;
`else
  localparam int DW = 24;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 9;
  localparam logic [3:0]    LAST_X    = 4'(BLOCKS_X - 1);
  localparam logic [3:0]    LAST_Y    = 4'(BLOCKS_Y - 1);
  localparam logic [PW-1:0] TOTAL_P   = PW'(BLOCKS_X * BLOCKS_Y);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d, rptr_inc;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    blkx_q, blky_q, blkx_d, blky_d, cur_x, cur_y;
  logic [PW-1:0] popcnt_q, popcnt_d, pc_base, pc_inc;
  logic [15:0]   sum_q, sum_d, sum_base;
  logic [16:0]   sum_ext;
  logic          ov_q, ov_d, done_q, done_d;
  logic [DW-1:0] data_q, data_d, entry;
  logic          pop, full, accept, drop;
`ifdef MV_SKIP_EN
  logic          skip_w;
  logic [7:0]    skip_q, skip_d, skip_base;
`endif

  assign pop      = (count_q != '0) && out_ready;
  assign full     = (count_q == CNT_FULL);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign accept   = me_done && (!full || pop);
  assign drop     = me_done && full && !pop;
  assign rptr_inc = rptr_q + AW'(1);

  // frame_start takes priority over the stored position for a coincident push.
  assign cur_x = frame_start ? 4'd0 : blkx_q;
  assign cur_y = frame_start ? 4'd0 : blky_q;

`ifdef MV_SKIP_EN
  assign skip_w = (BestDist <= 8'(SKIP_THRESH));
  assign entry  = {skip_w, cur_y, cur_x, BestDist, motionY, motionX};
`else
  assign entry  = {cur_y, cur_x, BestDist, motionY, motionX};
`endif

  always_comb begin
    // Position advances on every me_done, dropped or not, to keep tags aligned.
    blkx_d = cur_x;
    blky_d = cur_y;
    if (me_done) begin
      if (cur_x == LAST_X) begin
        blkx_d = 4'd0;
        blky_d = (cur_y == LAST_Y) ? 4'd0 : cur_y + 4'd1;
      end else begin
        blkx_d = cur_x + 4'd1;
      end
    end

    sum_base = frame_start ? 16'd0 : sum_q;
    sum_ext  = {1'b0, sum_base} + {9'd0, BestDist};
    sum_d    = sum_base;
    if (accept) sum_d = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];

    pc_base  = frame_start ? '0 : popcnt_q;
    pc_inc   = pc_base + PW'(1);
    popcnt_d = pc_base;
    done_d   = 1'b0;
    if (pop) begin
      if (pc_inc == TOTAL_P) begin
        popcnt_d = '0;
        done_d   = 1'b1;
      end else begin
        popcnt_d = pc_inc;
      end
    end

    ov_d = (frame_start ? 1'b0 : ov_q) | drop;

    wptr_d  = accept ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_inc : rptr_q;
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CNT_ONE;
    else if (!accept && pop) count_d = count_q - CNT_ONE;

    // Registered show-ahead head: a push into an (about to be) empty FIFO
    // becomes the head directly; otherwise a pop exposes the next stored
    // entry; an empty FIFO keeps the last head.
    data_d = data_q;
    if (accept && ((count_q == '0) || ((count_q == CNT_ONE) && pop)))
      data_d = entry;
    else if (pop && (count_q > CNT_ONE))
      data_d = mem_q[rptr_inc];

`ifdef MV_SKIP_EN
    skip_base = frame_start ? 8'd0 : skip_q;
    skip_d    = skip_base;
    if (accept && skip_w && (skip_base != 8'hFF)) skip_d = skip_base + 8'd1;
`endif
  end

  // Storage carries no reset; occupancy is governed by the pointers/count.
  always_ff @(posedge clock) begin
    if (accept) mem_q[wptr_q] <= entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      blkx_q   <= 4'd0;
      blky_q   <= 4'd0;
      popcnt_q <= '0;
      sum_q    <= 16'd0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
`ifdef MV_SKIP_EN
      skip_q   <= 8'd0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      blkx_q   <= blkx_d;
      blky_q   <= blky_d;
      popcnt_q <= popcnt_d;
      sum_q    <= sum_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
      data_q   <= data_d;
`ifdef MV_SKIP_EN
      skip_q   <= skip_d;
`endif
    end
  end

  assign out_valid     = (count_q != '0);
  assign out_data      = data_q;
  assign count         = count_q;
  assign frame_sad_sum = sum_q;
  assign frame_done    = done_q;
  assign overflow      = ov_q;
`ifdef MV_SKIP_EN
  assign skip_count    = skip_q;
`endif

endmodule
`default_nettype wire

// File: doc/me_result_fifo.md
Name: me_result_fifo

Overview:
- Sits directly downstream of MotionEstimator and captures each block's result (BestDist, motionX, motionY) when the estimator signals completion.
- Tags each result with its raster block position in the frame and buffers it in a small FIFO.
- Presents results to the bitstream/packer stage over a valid/ready handshake.
- Keeps per-frame bookkeeping: result count, SAD sum, frame-done pulse and a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- BLOCKS_X, 4, 16x16 blocks per frame row; minimum 1, maximum 16.
- BLOCKS_Y, 4, block rows per frame; minimum 1, maximum 16.
- SKIP_THRESH, 8, BestDist threshold at or below which a block is flagged skip (used only with MV_SKIP_EN).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; clears frame bookkeeping and block position.
- me_done  in  1  one-cycle pulse from MotionEstimator; result inputs are valid in this cycle.
- BestDist  in  8  best SAD distance from MotionEstimator.
- motionX  in  4  horizontal motion vector, unsigned.
- motionY  in  4  vertical motion vector, unsigned.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  24 (25 with MV_SKIP_EN)  packed entry, MSB to LSB: {[skip], blkY[3:0], blkX[3:0], BestDist[7:0], motionY[3:0], motionX[3:0]}.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- frame_sad_sum  out  16  sum of BestDist over the results accepted this frame.
- frame_done  out  1  one-cycle pulse when the last block of the frame is popped.
- overflow  out  1  sticky flag: a result was dropped.

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0; FIFO pointers, count, block position (blkX, blkY) and pop counter reset to 0.
- Push: on me_done, the entry is written using the current blkX/blkY. Then blkX increments; at BLOCKS_X-1, blkX wraps to 0 and blkY increments; at the last block, both wrap to 0.
- Pop: fires when out_valid && out_ready. The read pointer advances the next cycle.
- FIFO is show-ahead.
  - out_data always equals the head entry while out_valid=1.
  - out_data holds its last value while empty.
  - out_valid = (count != 0).
- Latency: me_done in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop:
  - Not full: both take effect; count is unchanged.
  - Full: the pop frees a slot and the push is accepted; no overflow.
- Full without pop: the push is dropped and overflow is set.
  - On a dropped push, blkX/blkY still advance, so later tags stay positionally correct.
  - On a dropped push, frame_sad_sum does not change.
- Empty with out_ready=1: nothing happens; count does not underflow.
- frame_sad_sum adds BestDist on each accepted push and saturates at 16'hFFFF.
- frame_done:
  - A pop counter increments on each pop.
  - When a pop brings it to BLOCKS_X*BLOCKS_Y, frame_done pulses in the next cycle and the counter clears.
- frame_start:
  - Clears blkX, blkY, frame_sad_sum, the pop counter and overflow.
  - Does not flush the FIFO; entries already queued still drain.
  - If me_done coincides with frame_start, the push uses position (0,0) and the sum becomes BestDist.
- Reset mid-operation: the FIFO is emptied immediately, out_valid drops asynchronously, and all bookkeeping clears.
- Widths: blkX/blkY are 4-bit and fixed; parameters above 16 are illegal.

Optional Feature:
- Macro: MV_SKIP_EN.
- Defined:
  - out_data is 25 bits; bit 24 = (BestDist <= SKIP_THRESH), computed at push time.
  - Adds output skip_count (8 bits, saturating), counting accepted skip pushes; it clears on reset and on frame_start.
- Undefined: out_data is 24 bits, and neither the skip logic nor the skip_count port exists.

Test Plan:
- Single push, empty FIFO:
  - Stimulus: me_done with BestDist=0x23, X=5, Y=9 after frame_start, out_ready=0.
  - Response: next cycle out_valid=1, out_data=24'h00_23_95, count=1, frame_sad_sum=0x23.
- Fill and overflow:
  - Stimulus: 9 pushes with out_ready=0 (DEPTH=8).
  - Response: count=8, overflow=1, the 9th entry is absent, and the next push tag is blkX=1, blkY=2.
- Full with simultaneous push and pop:
  - Stimulus: full FIFO, me_done and out_ready both high.
  - Response: count stays 8, overflow stays 0, the new entry is last out.
- Full frame:
  - Stimulus: 16 pushes interleaved with pops, out_ready=1.
  - Response: tags go (0,0)..(3,3) in raster order, frame_done pulses exactly once after the 16th pop, and the next push tags (0,0).
- Saturation:
  - Stimulus: 300 pushes of BestDist=0xFF with frame BLOCKS 16x16, out_ready=1.
  - Response: frame_sad_sum = 0xFFFF (saturated), no wrap.
- Reset mid-operation:
  - Stimulus: 3 entries queued, reset asserted between clock edges.
  - Response: out_valid=0 and count=0 immediately; after release, a push tags (0,0). With MV_SKIP_EN, BestDist=8 sets bit 24 and skip_count=1.
